sram_wb_master: RTL and testbench

Command-driven Wishbone classic initiator that performs single-word block reads and writes against the SRAM Wishbone slave wrapper. It sits between a local control source and the SRAM slave. It accepts one block command at a time and steps through consecutive word addresses. Write data arrives on a valid/ready input stream; read data leaves on a valid/ready output stream. A timeout aborts the command if the slave never acknowledges.

---
 rtl/sram_wb_master_pkg.sv | 19 +
 rtl/sram_wb_master.sv | 190 +++++++++++++++++++
 tb/tb_sram_wb_master.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_wb_master_pkg.sv
// rtl/sram_wb_master_pkg.sv - shared types and sizing helpers for the SRAM Wishbone block master
package sram_wb_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    REQ   = 2'd2,
    RDOUT = 2'd3
  } state_t;

  localparam int TIMEOUT_DEFAULT = 16;
  localparam int TO_WD           = $clog2(TIMEOUT_DEFAULT + 1);

  // Counter width able to hold the value TIMEOUT itself.
  function automatic int to_wd(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/sram_wb_master.sv
// rtl/sram_wb_master.sv - command-driven Wishbone classic initiator for single-word block reads/writes
module sram_wb_master
  import sram_wb_master_pkg::*;
#(
  parameter int ADDR_WD = 8,
  parameter int DATA_WD = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [ADDR_WD-1:0]   cmd_addr_i,
  input  logic [ADDR_WD-1:0]   cmd_len_i,
  input  logic [DATA_WD/8-1:0] cmd_sel_i,
  input  logic [DATA_WD-1:0]   wr_data_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  output logic [DATA_WD-1:0]   rd_data_o,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [ADDR_WD-1:0]   wb_adr_o,
  output logic [DATA_WD-1:0]   wb_dat_o,
  output logic [DATA_WD/8-1:0] wb_sel_o,
  input  logic [DATA_WD-1:0]   wb_dat_i,
  input  logic                 wb_ack_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int SEL_WD = DATA_WD / 8;
  localparam int CNT_WD = to_wd(TIMEOUT);
  localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(TIMEOUT - 1);

  state_t               state_q, state_n;
  logic [ADDR_WD-1:0]   adr_q, adr_n;
  logic [ADDR_WD-1:0]   rem_q, rem_n;
  logic                 we_q, we_n;
  logic [SEL_WD-1:0]    sel_q, sel_n;
  logic [DATA_WD-1:0]   dat_q, dat_n;
  logic                 stb_q, stb_n;
  logic [DATA_WD-1:0]   rd_data_q, rd_data_n;
  logic                 rd_valid_q, rd_valid_n;
  logic                 done_q, done_n;
  logic                 err_q, err_n;
  logic [CNT_WD-1:0]    cnt_q, cnt_n;

  logic                 last_word;
  assign last_word = (rem_q == '0);

  always_ff @(posedge wb_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      adr_q      <= '0;
      rem_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      dat_q      <= '0;
      stb_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_n;
      adr_q      <= adr_n;
      rem_q      <= rem_n;
      we_q       <= we_n;
      sel_q      <= sel_n;
      dat_q      <= dat_n;
      stb_q      <= stb_n;
      rd_data_q  <= rd_data_n;
      rd_valid_q <= rd_valid_n;
      done_q     <= done_n;
      err_q      <= err_n;
      cnt_q      <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    adr_n      = adr_q;
    rem_n      = rem_q;
    we_n       = we_q;
    sel_n      = sel_q;
    dat_n      = dat_q;
    stb_n      = stb_q;
    rd_data_n  = rd_data_q;
    rd_valid_n = rd_valid_q;
    done_n     = 1'b0;
    err_n      = err_q;
    cnt_n      = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          adr_n = cmd_addr_i;
          rem_n = cmd_len_i;
          we_n  = cmd_we_i;
          sel_n = cmd_sel_i;
          err_n = 1'b0;
          if (cmd_we_i) begin
            state_n = WDATA;
          end else begin
            // Reads hit the bus on the accept edge itself.
            state_n = REQ;
            stb_n   = 1'b1;
            cnt_n   = '0;
          end
        end
      end

      WDATA: begin
        if (wr_valid_i) begin
          dat_n   = wr_data_i;
          state_n = REQ;
          stb_n   = 1'b1;
          cnt_n   = '0;
        end
      end

      REQ: begin
        if (wb_ack_i) begin
          stb_n = 1'b0;
          if (!we_q) begin
            rd_data_n  = wb_dat_i;
            rd_valid_n = 1'b1;
            state_n    = RDOUT;
          end else if (last_word) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            adr_n   = adr_q + ADDR_WD'(1);
            rem_n   = rem_q - ADDR_WD'(1);
            state_n = WDATA;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Slave never answered: abandon the rest of the block.
          stb_n   = 1'b0;
          err_n   = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q + CNT_WD'(1);
        end
      end

      RDOUT: begin
        if (rd_ready_i) begin
          rd_valid_n = 1'b0;
          if (last_word) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            adr_n   = adr_q + ADDR_WD'(1);
            rem_n   = rem_q - ADDR_WD'(1);
            state_n = REQ;
            stb_n   = 1'b1;
            cnt_n   = '0;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign wr_ready_o  = (state_q == WDATA);
  assign busy_o      = (state_q != IDLE);

  assign wb_cyc_o    = stb_q;
  assign wb_stb_o    = stb_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;

  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_sram_wb_master.sv
// tb/tb_sram_wb_master.sv - directed bench for sram_wb_master with a 1-cycle-ack SRAM slave model
module tb_sram_wb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [3:0]  cmd_sel = '0;
  logic [31:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic        wb_cyc, wb_stb, wb_we;
  logic [7:0]  wb_adr;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;
  logic        wb_ack;
  logic        busy, done, err;

  logic        s_ack;
  logic [31:0] s_dat;
  logic        slave_en = 1'b1;
  logic        ack_force = 1'b0;
  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_wb_master #(.ADDR_WD(8), .DATA_WD(32), .TIMEOUT(16)) dut (
    .wb_clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_sel_i(cmd_sel),
    .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  // SRAM slave: registered ack one cycle after stb, toggling so it never double-acks.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack <= 1'b0;
      s_dat <= '0;
    end else begin
      s_ack <= slave_en && wb_cyc && wb_stb && !s_ack;
      if (slave_en && wb_cyc && wb_stb && !s_ack) begin
        if (wb_we) begin
          for (int b = 0; b < 4; b++)
            if (wb_sel[b]) mem[wb_adr][8*b +: 8] <= wb_dat_o[8*b +: 8];
        end else begin
          s_dat <= mem[wb_adr];
        end
      end
    end
  end
  assign wb_ack   = s_ack | ack_force;
  assign wb_dat_i = s_dat;

  // Write-stream feeder: presents feed_data in order, with an optional initial stall.
  logic [31:0] feed_data [0:3];
  int feed_n = 0;
  int fidx = 0;
  int stall_left = 0;
  logic hs_prev = 1'b0;
  always begin
    @(negedge clk);
    #1;
    if (hs_prev) fidx++;
    wr_valid = (fidx < feed_n) && (stall_left == 0);
    if (stall_left > 0) stall_left--;
    wr_data  = (fidx < 4) ? feed_data[fidx] : 32'h0;
    hs_prev  = wr_valid && wr_ready;
  end

  // Bus / stream monitor.
  logic [7:0]  adr_log [$];
  logic [31:0] rd_log [$];
  int stb_runs [$];
  int stb_run = 0;
  int done_cnt = 0;
  always begin
    @(negedge clk);
    #2;
    if (wb_stb) stb_run++;
    else if (stb_run != 0) begin
      stb_runs.push_back(stb_run);
      stb_run = 0;
    end
    if (wb_stb && wb_ack) adr_log.push_back(wb_adr);
    if (rd_valid && rd_ready) rd_log.push_back(rd_data);
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_logs();
    adr_log.delete();
    rd_log.delete();
    stb_runs.delete();
    done_cnt = 0;
  endtask

  task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] len, input logic [3:0] sel);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_sel   = sel;
  endtask

  // Counts negedges after the issuing negedge until done_o is seen; 0 if the bound expires.
  task automatic wait_done(input int limit, output int lat);
    lat = 0;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (i == 1) cmd_valid = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat;
  int n;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    step();
    mem[8'hFE] <= 32'hCAFE_00FE;
    mem[8'hFF] <= 32'hCAFE_00FF;
    mem[8'h00] <= 32'hCAFE_0000;
    mem[8'h20] <= 32'h1122_3344;
    step();
    step();

    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy",      busy,      0);
    check("rst_stb",       wb_stb,    0);
    check("rst_cyc",       wb_cyc,    0);
    check("rst_done",      done,      0);
    check("rst_err",       err,       0);
    check("rst_rd_valid",  rd_valid,  0);
    check("rst_wr_ready",  wr_ready,  0);
    rst = 1'b0;
    step();

    // Write block: 0x10..0x13, data 0xA0..0xA3, wr_valid always high.
    clear_logs();
    feed_data[0] = 32'hA0; feed_data[1] = 32'hA1;
    feed_data[2] = 32'hA2; feed_data[3] = 32'hA3;
    fidx = 0; feed_n = 4;
    issue(1'b1, 8'h10, 8'd3, 4'hF);
    wait_done(40, lat);
    // done rises on edge E12 after the accept edge E0; first visible 13 negedges on.
    check("wr_done_latency", lat, 13);
    check("wr_err",          err, 0);
    step();
    check("wr_done_pulse",   done, 0);
    check("wr_idle",         busy, 0);
    check("wr_adr_count",    adr_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("wr_adr", (i < adr_log.size()) ? adr_log[i] : 8'hXX, 8'h10 + 8'(i));
      check("wr_mem", mem[8'h10 + 8'(i)], 32'hA0 + i);
      check("wr_stb_len", (i < stb_runs.size()) ? stb_runs[i] : 0, 2);
    end
    feed_n = 0; fidx = 0;

    // Read with address wrap 0xFE -> 0xFF -> 0x00.
    clear_logs();
    rd_ready = 1'b1;
    issue(1'b0, 8'hFE, 8'd2, 4'hF);
    wait_done(40, lat);
    check("rdw_done_latency", lat, 10);
    step();
    check("rdw_done_count",  done_cnt, 1);
    check("rdw_adr_count",   adr_log.size(), 3);
    check("rdw_adr0", (adr_log.size() > 0) ? adr_log[0] : 8'hXX, 8'hFE);
    check("rdw_adr1", (adr_log.size() > 1) ? adr_log[1] : 8'hXX, 8'hFF);
    check("rdw_adr2", (adr_log.size() > 2) ? adr_log[2] : 8'hXX, 8'h00);
    check("rdw_data_count",  rd_log.size(), 3);
    check("rdw_data0", (rd_log.size() > 0) ? rd_log[0] : 32'hX, 32'hCAFE_00FE);
    check("rdw_data1", (rd_log.size() > 1) ? rd_log[1] : 32'hX, 32'hCAFE_00FF);
    check("rdw_data2", (rd_log.size() > 2) ? rd_log[2] : 32'hX, 32'hCAFE_0000);

    // Read backpressure: hold rd_ready low 5 cycles with data waiting.
    clear_logs();
    rd_ready = 1'b0;
    issue(1'b0, 8'h10, 8'd1, 4'hF);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 1) cmd_valid = 1'b0;
      if (rd_valid) begin
        n = i;
        break;
      end
    end
    check("bp_valid_seen", n, 3);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", rd_valid, 1);
      check("bp_hold_data",  rd_data,  32'hA0);
      check("bp_no_stb",     wb_stb,   0);
      if (i < 4) step();
    end
    rd_ready = 1'b1;
    step();
    check("bp_valid_drop", rd_valid, 0);
    check("bp_stb_resume", wb_stb,   1);
    wait_done(20, lat);
    check("bp_done_seen", (lat != 0), 1);
    step();
    check("bp_data_count", rd_log.size(), 2);
    check("bp_data1", (rd_log.size() > 1) ? rd_log[1] : 32'hX, 32'hA1);

    // Write stall: wr_valid low for 4 cycles in WDATA, half-word byte enables.
    clear_logs();
    feed_data[0] = 32'h5555_AAAA;
    fidx = 0; feed_n = 1;
    stall_left = 5;
    issue(1'b1, 8'h20, 8'd0, 4'h3);
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("ws_stb_low",   wb_stb,   0);
      check("ws_wr_ready",  wr_ready, 1);
      step();
    end
    step();
    check("ws_stb_rise", wb_stb, 1);
    wait_done(20, lat);
    check("ws_done_seen", (lat != 0), 1);
    step();
    check("ws_mem_bytes", mem[8'h20], 32'h1122_AAAA);
    feed_n = 0; fidx = 0;

    // Timeout: slave never acks.
    clear_logs();
    slave_en = 1'b0;
    issue(1'b0, 8'h30, 8'd3, 4'hF);
    wait_done(40, lat);
    check("to_done_latency", lat, 17);
    check("to_err",          err, 1);
    check("to_cmd_ready",    cmd_ready, 1);
    check("to_busy",         busy, 0);
    step();
    check("to_stb_len", (stb_runs.size() > 0) ? stb_runs[0] : 0, 16);
    check("to_no_rdata", rd_log.size(), 0);
    check("to_err_sticky", err, 1);
    slave_en = 1'b1;
    issue(1'b0, 8'h10, 8'd0, 4'hF);
    step();
    cmd_valid = 1'b0;
    check("to_err_cleared", err, 0);
    wait_done(20, lat);
    check("to_next_done", (lat != 0), 1);
    step();
    check("to_next_data", (rd_log.size() > 0) ? rd_log[rd_log.size()-1] : 32'hX, 32'hA0);

    // Reset while in REQ, with a late ack arriving afterwards.
    slave_en = 1'b0;
    issue(1'b0, 8'h40, 8'd1, 4'hF);
    step();
    cmd_valid = 1'b0;
    step();
    step();
    check("rr_stb_before", wb_stb, 1);
    rst = 1'b1;
    ack_force = 1'b1;
    #1;
    check("rr_stb_async", wb_stb, 0);
    check("rr_cyc_async", wb_cyc, 0);
    check("rr_busy_async", busy, 0);
    step();
    rst = 1'b0;
    slave_en = 1'b1;
    step();
    step();
    check("rr_busy_after",  busy,      0);
    check("rr_done_after",  done,      0);
    check("rr_rdv_after",   rd_valid,  0);
    check("rr_ready_after", cmd_ready, 1);
    ack_force = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
